// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with debounce and a 4-digit BCD entry register.
// Rows are stepped on the shared scan tick; one key code is emitted per accepted press.
module keypad_scan #(
    parameter int DEB_TICKS = 4,
    parameter int CNT_BITS  = 3
) (
    input  logic       clk,
    input  logic       r_n,
    input  logic       scan,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [CNT_BITS:0] DEB_LIM = (CNT_BITS+1)'(DEB_TICKS);
    localparam logic [CNT_BITS:0] ONE_W   = (CNT_BITS+1)'(1);

    state_t              state, state_n;
    logic [1:0]          row_sel, row_sel_n;
    logic [1:0]          col_idx, col_idx_n;
    logic [CNT_BITS-1:0] deb_cnt, deb_cnt_n;
    logic [CNT_BITS-1:0] rel_cnt, rel_cnt_n;
    logic [CNT_BITS:0]   deb_inc, rel_inc;
    logic [3:0]          col_p0, col_s;
    logic                accept;
    logic [3:0]          key_code;

    function automatic logic [1:0] first_low(input logic [3:0] c);
        logic [1:0] idx;
        if (!c[0])      idx = 2'd0;
        else if (!c[1]) idx = 2'd1;
        else if (!c[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign deb_inc  = {1'b0, deb_cnt} + ONE_W;
    assign rel_inc  = {1'b0, rel_cnt} + ONE_W;
    assign key_code = key_map(row_sel, col_idx);
    assign key_held = (state == HELD);

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) state <= SCAN;
        else      state <= state_n;
    end

    always_comb begin
        state_n   = state;
        row_sel_n = row_sel;
        col_idx_n = col_idx;
        deb_cnt_n = deb_cnt;
        rel_cnt_n = rel_cnt;
        accept    = 1'b0;
        if (scan) begin
            case (state)
                SCAN: begin
                    if (col_s == 4'hF) begin
                        row_sel_n = row_sel + 2'd1;
                    end else begin
                        col_idx_n = first_low(col_s);
                        deb_cnt_n = CNT_BITS'(1);
                        state_n   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!col_s[col_idx]) begin
                        if (deb_inc >= DEB_LIM) begin
                            accept    = 1'b1;
                            deb_cnt_n = '0;
                            rel_cnt_n = '0;
                            state_n   = HELD;
                        end else begin
                            deb_cnt_n = deb_inc[CNT_BITS-1:0];
                        end
                    end else begin
                        // glitch: resume scanning past the bouncing row
                        deb_cnt_n = '0;
                        row_sel_n = row_sel + 2'd1;
                        state_n   = SCAN;
                    end
                end
                HELD: begin
                    if (col_s[col_idx]) begin
                        if (rel_inc >= DEB_LIM) begin
                            rel_cnt_n = '0;
                            row_sel_n = row_sel + 2'd1;
                            state_n   = SCAN;
                        end else begin
                            rel_cnt_n = rel_inc[CNT_BITS-1:0];
                        end
                    end else begin
                        rel_cnt_n = '0;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    // stage p0 -> col_s: two-flop synchroniser, then scan-gated control and entry register
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            col_p0    <= 4'hF;
            col_s     <= 4'hF;
            row_sel   <= 2'd0;
            row       <= 4'b1110;
            col_idx   <= 2'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key       <= 4'h0;
            key_valid <= 1'b0;
            d0        <= 4'hF;
            d1        <= 4'hF;
            d2        <= 4'hF;
            d3        <= 4'hF;
        end else begin
            col_p0    <= col;
            col_s     <= col_p0;
            row_sel   <= row_sel_n;
            row       <= ~(4'b0001 << row_sel_n);
            col_idx   <= col_idx_n;
            deb_cnt   <= deb_cnt_n;
            rel_cnt   <= rel_cnt_n;
            key_valid <= accept;
            if (accept) begin
                key <= key_code;
                if (key_code <= 4'h9) begin
                    d3 <= d2;
                    d2 <= d1;
                    d1 <= d0;
                    d0 <= key_code;
                end else if (key_code == 4'hE) begin
                    d0 <= 4'hF;
                    d1 <= 4'hF;
                    d2 <= 4'hF;
                    d3 <= 4'hF;
                end else if (key_code == 4'hF) begin
                    d0 <= d1;
                    d1 <= d2;
                    d2 <= d3;
                    d3 <= 4'hF;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical keypad model drives col from row, with directed
// scenarios and random press sequences checked against a key-table/digit-queue model.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       r_n;
    logic       scan;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;
    logic [3:0] d0, d1, d2, d3;

    logic [15:0] pressed;
    int checks = 0;
    int failures = 0;
    int vld_count = 0;

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0] row_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_scan #(.DEB_TICKS(4), .CNT_BITS(3)) dut (
        .clk(clk), .r_n(r_n), .scan(scan), .col(col), .row(row),
        .key(key), .key_valid(key_valid), .key_held(key_held),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3)
    );

    always #5 clk = ~clk;

    // switch matrix: a pressed key pulls its column low while its row is driven low
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    always @(posedge clk) if (key_valid) vld_count <= vld_count + 1;

    task automatic tick();
        repeat (3) @(posedge clk);
        @(negedge clk);
        scan = 1'b1;
        @(posedge clk);
        #1;
        scan = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        r_n = 1'b0;
        pressed = '0;
        scan = 1'b0;
        repeat (2) @(negedge clk);
        r_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic press_key(input int idx, input int hold, input int rel);
        pressed[idx] = 1'b1;
        repeat (hold) tick();
        pressed[idx] = 1'b0;
        repeat (rel) tick();
    endtask

    task automatic test_reset();
        int base;
        r_n = 1'b0; scan = 1'b0; pressed = '0;
        #12;
        checks++; if (row !== 4'b1110) begin failures++; $display("FAIL rst_row got=%b want=1110", row); end
        checks++; if (key !== 4'h0) begin failures++; $display("FAIL rst_key got=%h want=0", key); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rst_held got=%b want=0", key_held); end
        checks++; if ({d3,d2,d1,d0} !== 16'hFFFF) begin failures++; $display("FAIL rst_digits got=%h want=ffff", {d3,d2,d1,d0}); end
        @(negedge clk); r_n = 1'b1; @(negedge clk);
        base = vld_count;
        pressed[0] = 1'b1;
        tick(); tick();
        checks++; if (key_held !== 1'b0 || vld_count != base) begin failures++; $display("FAIL deb_pending held=%b pulses=%0d want 0/0", key_held, vld_count - base); end
        #3 r_n = 1'b0;
        #1;
        checks++; if (row !== 4'b1110) begin failures++; $display("FAIL mid_rst_row got=%b want=1110", row); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", key_valid); end
        checks++; if ({d3,d2,d1,d0} !== 16'hFFFF) begin failures++; $display("FAIL mid_rst_digits got=%h want=ffff", {d3,d2,d1,d0}); end
        pressed = '0;
        @(negedge clk); r_n = 1'b1;
        repeat (6) tick();
        checks++; if (vld_count != base) begin failures++; $display("FAIL post_rst_pulse got=%0d want=0", vld_count - base); end
        checks++; if (key !== 4'h0) begin failures++; $display("FAIL post_rst_key got=%h want=0", key); end
    endtask

    task automatic test_idle();
        do_reset();
        checks++; if (row !== row_seq[0]) begin failures++; $display("FAIL idle_row0 got=%b want=%b", row, row_seq[0]); end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (row !== row_seq[(k+1)%4]) begin
                failures++; $display("FAIL idle_row tick=%0d got=%b want=%b", k+1, row, row_seq[(k+1)%4]);
            end
        end
    endtask

    task automatic test_press5();
        int base;
        do_reset();
        base = vld_count;
        pressed[5] = 1'b1;
        repeat (4) tick();
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL p5_early got=%b want=0", key_valid); end
        tick();
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL p5_valid got=%b want=1", key_valid); end
        checks++; if (key !== 4'h5) begin failures++; $display("FAIL p5_key got=%h want=5", key); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL p5_held got=%b want=1", key_held); end
        repeat (5) tick();
        pressed[5] = 1'b0;
        repeat (3) tick();
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL p5_held_rel3 got=%b want=1", key_held); end
        tick();
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL p5_released got=%b want=0", key_held); end
        checks++; if (row !== 4'b1011) begin failures++; $display("FAIL p5_resume_row got=%b want=1011", row); end
        checks++; if (vld_count - base != 1) begin failures++; $display("FAIL p5_pulses got=%0d want=1", vld_count - base); end
        checks++; if ({d3,d2,d1,d0} !== 16'hFFF5) begin failures++; $display("FAIL p5_digits got=%h want=fff5", {d3,d2,d1,d0}); end
    endtask

    task automatic test_bounce();
        int base;
        do_reset();
        base = vld_count;
        pressed[8] = 1'b1;
        repeat (4) tick();
        pressed[8] = 1'b0;
        tick();
        checks++; if (row !== 4'b0111) begin failures++; $display("FAIL bounce_row got=%b want=0111", row); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL bounce_held got=%b want=0", key_held); end
        repeat (4) tick();
        checks++; if (vld_count != base) begin failures++; $display("FAIL bounce_pulses got=%0d want=0", vld_count - base); end
        press_key(8, 10, 6);
        checks++; if (vld_count - base != 1) begin failures++; $display("FAIL bounce_stable_pulses got=%0d want=1", vld_count - base); end
        checks++; if (key !== 4'h7) begin failures++; $display("FAIL bounce_stable_key got=%h want=7", key); end
    endtask

    task automatic test_entry();
        do_reset();
        press_key(0, 10, 6); press_key(1, 10, 6); press_key(2, 10, 6); press_key(4, 10, 6);
        checks++; if ({d3,d2,d1,d0} !== 16'h1234) begin failures++; $display("FAIL entry_1234 got=%h want=1234", {d3,d2,d1,d0}); end
        press_key(10, 10, 6);
        checks++; if ({d3,d2,d1,d0} !== 16'h2349) begin failures++; $display("FAIL entry_9 got=%h want=2349", {d3,d2,d1,d0}); end
        press_key(14, 10, 6);
        checks++; if (key !== 4'hF) begin failures++; $display("FAIL entry_hash_key got=%h want=f", key); end
        checks++; if ({d3,d2,d1,d0} !== 16'hF234) begin failures++; $display("FAIL entry_hash got=%h want=f234", {d3,d2,d1,d0}); end
        press_key(12, 10, 6);
        checks++; if (key !== 4'hE) begin failures++; $display("FAIL entry_star_key got=%h want=e", key); end
        checks++; if ({d3,d2,d1,d0} !== 16'hFFFF) begin failures++; $display("FAIL entry_star got=%h want=ffff", {d3,d2,d1,d0}); end
    endtask

    task automatic test_two_keys();
        int base;
        do_reset();
        base = vld_count;
        pressed[2] = 1'b1; pressed[3] = 1'b1;
        repeat (4) tick();
        checks++; if (key_valid !== 1'b1 || key !== 4'h3) begin failures++; $display("FAIL two_accept valid=%b key=%h want 1/3", key_valid, key); end
        repeat (2) tick();
        pressed[3] = 1'b0;
        repeat (6) tick();
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL two_c3_rel_held got=%b want=1", key_held); end
        pressed[2] = 1'b0;
        repeat (3) tick();
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL two_c2_rel3 got=%b want=1", key_held); end
        tick();
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL two_c2_rel4 got=%b want=0", key_held); end
        checks++; if (vld_count - base != 1 || key !== 4'h3) begin failures++; $display("FAIL two_pulses got=%0d key=%h want 1/3", vld_count - base, key); end
    endtask

    task automatic test_random();
        logic [3:0] digq [$];
        int base, idx, hold, rel;
        logic [3:0] k;
        do_reset();
        digq = '{4'hF, 4'hF, 4'hF, 4'hF};
        for (int n = 0; n < 20; n++) begin
            idx  = int'($urandom_range(0, 15));
            hold = int'($urandom_range(8, 14));
            rel  = int'($urandom_range(5, 8));
            base = vld_count;
            press_key(idx, hold, rel);
            k = kmap[idx];
            if (k <= 4'h9) begin
                digq.push_front(k);
                digq.delete(4);
            end else if (k == 4'hE) begin
                digq = '{4'hF, 4'hF, 4'hF, 4'hF};
            end else if (k == 4'hF) begin
                digq.delete(0);
                digq.push_back(4'hF);
            end
            checks++; if (vld_count - base != 1) begin failures++; $display("FAIL rnd_pulses n=%0d got=%0d want=1", n, vld_count - base); end
            checks++; if (key !== k) begin failures++; $display("FAIL rnd_key n=%0d got=%h want=%h", n, key, k); end
            checks++;
            if ({d3,d2,d1,d0} !== {digq[3],digq[2],digq[1],digq[0]}) begin
                failures++; $display("FAIL rnd_digits n=%0d got=%h want=%h", n, {d3,d2,d1,d0}, {digq[3],digq[2],digq[1],digq[0]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press5();
        test_bounce();
        test_entry();
        test_two_keys();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
